dmem_line_store: RTL and testbench

- Main-memory model sitting directly downstream of the data-cache system.
- Consumes addr_mem / rd_mem / wr_mem and 128-bit write-back lines from the cache.
- Returns 128-bit lines on data_out_mem with a fixed, parameterised latency.
- Counts serviced reads and writes for the same hit/total statistics flow the cache uses.

---
 rtl/dmem_line_store.sv | 149 ++++++++++++++
 tb/tb_dmem_line_store.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_line_store.sv
// Line-granular main-memory model behind the data cache: fixed-latency 128-bit line
// reads and writes, a sticky out-of-range flag and wrapping read/write completion counters.
module dmem_line_store #(
  parameter int unsigned line_addr_bits = 8,
  parameter int unsigned lat            = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr_mem,
  input  logic         rd_mem,
  input  logic         wr_mem,
  input  logic [127:0] data_in_mem,
  output logic [127:0] data_out_mem,
  output logic         mem_busy,
  output logic         mem_ready,
  output logic         mem_err,
  output logic [11:0]  rd_cnt,
  output logic [11:0]  wr_cnt
);

  localparam int unsigned Depth = 2 ** line_addr_bits;
  localparam logic [3:0]  LatM1 = 4'(lat - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [line_addr_bits-1:0] line_q, line_d;
  logic                      oor_q, oor_d;
  logic [127:0]              data_q, data_d;
  logic [127:0]              dout_q, dout_d;
  logic                      err_q, err_d;
  logic [11:0]               rd_cnt_q, rd_cnt_d;
  logic [11:0]               wr_cnt_q, wr_cnt_d;
  logic [127:0]              mem_q [Depth];

  logic accept, oor_in, last, wr_en;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^addr_mem[3:0];
  assign oor_in = |(addr_mem[31:4] >> line_addr_bits);
  assign accept = (state_q == StIdle) && (rd_mem || wr_mem);
  assign last   = (cnt_q == 4'd0);
  // Out-of-range writes still take full latency but never touch the array.
  assign wr_en  = (state_q == StWrite) && last && !oor_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wr_mem) begin
          state_d = StWrite;
        end else if (rd_mem) begin
          state_d = StRead;
        end
      end
      StRead:  if (last) state_d = StDone;
      StWrite: if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mem_busy     = (state_q == StRead) || (state_q == StWrite);
    mem_ready    = (state_q == StDone);
    mem_err      = err_q;
    data_out_mem = dout_q;
    rd_cnt       = rd_cnt_q;
    wr_cnt       = wr_cnt_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d    = cnt_q;
    line_d   = line_q;
    oor_d    = oor_q;
    data_d   = data_q;
    dout_d   = dout_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept) begin
      cnt_d  = LatM1;
      line_d = addr_mem[4 +: line_addr_bits];
      oor_d  = oor_in;
      data_d = data_in_mem;
      if (oor_in) begin
        err_d = 1'b1;
      end
    end
    if ((state_q == StRead) || (state_q == StWrite)) begin
      if (!last) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
    // The read line is captured on the first edge after accept and then held.
    if ((state_q == StRead) && (cnt_q == LatM1)) begin
      dout_d = oor_q ? '0 : mem_q[line_q];
    end
    if ((state_q == StRead) && last) begin
      rd_cnt_d = rd_cnt_q + 12'd1;
    end
    if ((state_q == StWrite) && last) begin
      wr_cnt_d = wr_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      line_q   <= '0;
      oor_q    <= 1'b0;
      data_q   <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      oor_q    <= oor_d;
      data_q   <= data_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[line_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_dmem_line_store.sv
// Self-checking bench for dmem_line_store: expected read lines are queued at issue and
// compared when mem_ready pulses.
module tb_dmem_line_store;

  localparam int unsigned Lat = 5;
  localparam logic [127:0] LineA = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] LineAa = {32{4'hA}};
  localparam logic [127:0] Line55 = {32{4'h5}};
  localparam logic [127:0] LineBb = {32{4'hB}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr_mem = '0;
  logic         rd_mem = 1'b0;
  logic         wr_mem = 1'b0;
  logic [127:0] data_in_mem = '0;
  logic [127:0] data_out_mem;
  logic         mem_busy, mem_ready, mem_err;
  logic [11:0]  rd_cnt, wr_cnt;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp;
  int ra, bn;
  logic [127:0] d1;

  always #5 clk = ~clk;

  dmem_line_store #(
    .line_addr_bits(8),
    .lat           (Lat)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr_mem    (addr_mem),
    .rd_mem      (rd_mem),
    .wr_mem      (wr_mem),
    .data_in_mem (data_in_mem),
    .data_out_mem(data_out_mem),
    .mem_busy    (mem_busy),
    .mem_ready   (mem_ready),
    .mem_err     (mem_err),
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt)
  );

  // Drives one request into an idle DUT and waits (bounded) for its completion pulse.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [127:0] data, output int ready_at, output int busy_n,
                       output logic [127:0] dout_t1);
    @(negedge clk);
    rd_mem = rd; wr_mem = wr; addr_mem = addr; data_in_mem = data;
    @(posedge clk);
    #1;
    rd_mem = 1'b0; wr_mem = 1'b0; addr_mem = 32'h0000_0FF0;
    data_in_mem = {$urandom, $urandom, $urandom, $urandom};
    ready_at = -1; busy_n = 0; dout_t1 = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_busy) busy_n++;
      if (n == 2) dout_t1 = data_out_mem;
      if (mem_ready) begin
        ready_at = n;
        break;
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_out_mem !== '0 || mem_busy !== 1'b0 || mem_ready !== 1'b0 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got dout=%h busy=%b ready=%b err=%b, want all 0",
               data_out_mem, mem_busy, mem_ready, mem_err);
    end
    checks++;
    if (rd_cnt !== 12'd0 || wr_cnt !== 12'd0) begin
      failures++;
      $display("FAIL reset_counters: got rd=%0d wr=%0d, want 0 0", rd_cnt, wr_cnt);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_busy !== 1'b0 || mem_ready !== 1'b0 || data_out_mem !== '0) begin
      failures++;
      $display("FAIL reset_release_idle: got busy=%b ready=%b dout=%h, want 0 0 0",
               mem_busy, mem_ready, data_out_mem);
    end
  endtask

  task automatic test_write_read();
    issue(1'b0, 1'b1, 32'h0000_0040, LineA, ra, bn, d1);
    checks++;
    if (ra !== Lat + 1 || bn !== Lat) begin
      failures++;
      $display("FAIL write_latency: got ready_at=%0d busy_cycles=%0d, want %0d %0d",
               ra, bn, Lat + 1, Lat);
    end
    checks++;
    if (wr_cnt !== 12'd1 || rd_cnt !== 12'd0 || mem_busy !== 1'b0) begin
      failures++;
      $display("FAIL write_counts: got wr=%0d rd=%0d busy=%b, want 1 0 0", wr_cnt, rd_cnt, mem_busy);
    end
    exp_q.push_back(LineA);
    issue(1'b1, 1'b0, 32'h0000_004C, '0, ra, bn, d1);
    checks++;
    if (d1 !== exp_q[0]) begin
      failures++;
      $display("FAIL read_data_t0p1: got %h want %h", d1, exp_q[0]);
    end
    exp = exp_q.pop_front();
    checks++;
    if (data_out_mem !== exp || ra !== Lat + 1) begin
      failures++;
      $display("FAIL read_data_ready: got %h ready_at=%0d, want %h %0d", data_out_mem, ra, exp, Lat + 1);
    end
    checks++;
    if (rd_cnt !== 12'd1) begin
      failures++;
      $display("FAIL read_count: got %0d want 1", rd_cnt);
    end
  endtask

  task automatic test_both();
    reset_pulse();
    issue(1'b1, 1'b1, 32'h0000_0080, LineAa, ra, bn, d1);
    checks++;
    if (wr_cnt !== 12'd1 || rd_cnt !== 12'd0 || data_out_mem !== '0 || ra !== Lat + 1) begin
      failures++;
      $display("FAIL both_write_wins: got wr=%0d rd=%0d dout=%h ready_at=%0d, want 1 0 0 %0d",
               wr_cnt, rd_cnt, data_out_mem, ra, Lat + 1);
    end
    exp_q.push_back(LineAa);
    issue(1'b1, 1'b0, 32'h0000_0080, '0, ra, bn, d1);
    exp = exp_q.pop_front();
    checks++;
    if (data_out_mem !== exp || wr_cnt !== 12'd1 || rd_cnt !== 12'd1) begin
      failures++;
      $display("FAIL both_readback: got %h wr=%0d rd=%0d, want %h 1 1", data_out_mem, wr_cnt, rd_cnt, exp);
    end
    issue(1'b0, 1'b1, 32'h0000_0090, Line55, ra, bn, d1);
    checks++;
    if (data_out_mem !== LineAa) begin
      failures++;
      $display("FAIL dout_held_over_write: got %h want %h", data_out_mem, LineAa);
    end
  endtask

  task automatic test_out_of_range();
    reset_pulse();
    exp_q.push_back('0);
    issue(1'b1, 1'b0, 32'h0000_1000, '0, ra, bn, d1);
    exp = exp_q.pop_front();
    checks++;
    if (mem_err !== 1'b1 || data_out_mem !== exp || rd_cnt !== 12'd1 || ra !== Lat + 1) begin
      failures++;
      $display("FAIL oor_read: got err=%b dout=%h rd=%0d ready_at=%0d, want 1 %h 1 %0d",
               mem_err, data_out_mem, rd_cnt, ra, exp, Lat + 1);
    end
    issue(1'b0, 1'b1, 32'h0000_1040, Line55, ra, bn, d1);
    checks++;
    if (mem_err !== 1'b1 || wr_cnt !== 12'd1 || ra !== Lat + 1) begin
      failures++;
      $display("FAIL oor_write: got err=%b wr=%0d ready_at=%0d, want 1 1 %0d", mem_err, wr_cnt, ra, Lat + 1);
    end
    exp_q.push_back(LineA);
    issue(1'b1, 1'b0, 32'h0000_0040, '0, ra, bn, d1);
    exp = exp_q.pop_front();
    checks++;
    if (data_out_mem !== exp || mem_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_array_unchanged: got %h err=%b, want %h 1", data_out_mem, mem_err, exp);
    end
  endtask

  task automatic test_reset_abort();
    reset_pulse();
    checks++;
    if (mem_err !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared_by_reset: got %b want 0", mem_err);
    end
    @(negedge clk);
    wr_mem = 1'b1; addr_mem = 32'h0000_0040; data_in_mem = LineBb;
    @(posedge clk);
    #1;
    wr_mem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_busy !== 1'b0 || wr_cnt !== 12'd0 || mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_immediate: got busy=%b wr=%0d ready=%b, want 0 0 0", mem_busy, wr_cnt, mem_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    exp_q.push_back(LineA);
    issue(1'b1, 1'b0, 32'h0000_0040, '0, ra, bn, d1);
    exp = exp_q.pop_front();
    checks++;
    if (data_out_mem !== exp || wr_cnt !== 12'd0 || rd_cnt !== 12'd1) begin
      failures++;
      $display("FAIL abort_no_write: got %h wr=%0d rd=%0d, want %h 0 1", data_out_mem, wr_cnt, rd_cnt, exp);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, dmis, cmis, spacing_bad, last_cyc, snap;
    pulses = 0; dmis = 0; cmis = 0; spacing_bad = 0; last_cyc = 0; snap = -1;
    reset_pulse();
    for (int i = 0; i < 4096; i++) exp_q.push_back(LineAa);
    @(negedge clk);
    rd_mem = 1'b1; addr_mem = 32'h0000_0080;
    for (int cyc = 1; cyc <= 4096 * (Lat + 3) + 20; cyc++) begin
      @(negedge clk);
      if (mem_ready) begin
        pulses++;
        exp = exp_q.pop_front();
        if (data_out_mem !== exp) dmis++;
        if (rd_cnt !== 12'(pulses)) cmis++;
        if (pulses > 1 && (cyc - last_cyc) < Lat + 1) spacing_bad++;
        last_cyc = cyc;
        if (pulses == 4095) snap = int'(rd_cnt);
        if (pulses == 4096) begin
          rd_mem = 1'b0;
          break;
        end
      end
    end
    rd_mem = 1'b0;
    checks++;
    if (pulses !== 4096) begin
      failures++;
      $display("FAIL b2b_completions: got %0d want 4096", pulses);
    end
    checks++;
    if (snap !== 4095 || rd_cnt !== 12'd0) begin
      failures++;
      $display("FAIL b2b_wrap: got at4095=%0d final=%0d, want 4095 0", snap, rd_cnt);
    end
    checks++;
    if (dmis !== 0 || cmis !== 0 || spacing_bad !== 0) begin
      failures++;
      $display("FAIL b2b_stream: got data_err=%0d count_err=%0d spacing_err=%0d, want 0 0 0",
               dmis, cmis, spacing_bad);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mem_busy !== 1'b0 || wr_cnt !== 12'd0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_quiesce: got busy=%b wr=%0d left=%0d, want 0 0 0", mem_busy, wr_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_both();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
